sd_blk_server: RTL and testbench
================================

SD_BLK_SERVER -- requirements
Module: sd_blk_server

Interface
REQ-001 SHALL have parameter NDRIVES, default 4: number of drive request channels served.
REQ-002 SHALL have parameter MEM_AW, default 22: backing-store byte address width, {drive[1:0], lba[10:0], offset[8:0]}.
REQ-003 SHALL have port CLK, input, 1: single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port sd_lba[4], input, 32 each: block address per drive, valid while that drive's request is high.
REQ-006 SHALL have ports sd_rd / sd_wr, input, 4: per-drive level read / write block requests.
REQ-007 SHALL have port sd_ack, output, 4: per-drive transfer-in-progress acknowledge.
REQ-008 SHALL have ports sd_buff_addr (output, 9), sd_buff_dout (output, 8) and sd_buff_wr (output, 1): byte index, read data and write strobe into the client buffer.
REQ-009 SHALL have port sd_buff_din[4], input, 8 each: client buffer read data, valid 1 cycle after sd_buff_addr.
REQ-010 SHALL have ports cfg_wr (input, 1), cfg_drive (input, 2) and cfg_size (input, 20): image size load, in bytes.
REQ-011 SHALL have ports mem_addr (output, MEM_AW), mem_rd, mem_wr (output, 1), mem_wdata (output, 8), mem_rdata (input, 8) and mem_ready (input, 1): backing-store port.
REQ-012 SHALL have port blk_err, output, 1: one-cycle pulse at the end of an out-of-range transfer.

Function
REQ-013 SHALL implement states IDLE, GRANT, RD_REQ, RD_PUSH, WR_ADDR, WR_SAMPLE, WR_REQ, DONE.
REQ-014 IDLE SHALL pick, among armed drives with sd_rd|sd_wr high, the first one in round-robin order after the last drive served (drive 0 first after reset), then go to GRANT.
REQ-015 When a drive has sd_rd and sd_wr high together, the read SHALL be served; the write SHALL stay pending.
REQ-016 GRANT SHALL latch lba[10:0], the operation and the drive; set sd_ack[drive]=1; clear the byte counter to 0; clear the drive's arm bit.
REQ-017 A drive's arm bit SHALL set when its sd_rd and sd_wr are both sampled low; the bit resets to 1.
REQ-018 A block SHALL be in range iff cfg_size[drive] != 0 and lba < cfg_size[drive][19:9].
REQ-019 An out-of-range block SHALL still complete a full 512-byte exchange with no mem_rd or mem_wr; reads SHALL return 0x00 bytes.
REQ-020 mem_addr SHALL be {drive, lba[10:0], cnt[8:0]}.
REQ-021 mem_rd and mem_wr SHALL be held with a stable address and data until the cycle mem_ready=1; mem_rdata SHALL be captured in that cycle.
REQ-022 Read (RD_REQ -> RD_PUSH) SHALL fetch byte cnt, then pulse sd_buff_wr for 1 cycle with sd_buff_addr=cnt and sd_buff_dout=data.
REQ-023 After RD_PUSH, a read SHALL increment cnt and return to RD_REQ, or go to DONE after cnt=511.
REQ-024 Write (WR_ADDR -> WR_SAMPLE) SHALL drive sd_buff_addr=cnt, sample sd_buff_din[drive] 1 cycle later, and issue mem_wr in WR_REQ.
REQ-025 After WR_REQ, a write SHALL increment cnt and return to WR_ADDR, or go to DONE after cnt=511.
REQ-026 Bytes SHALL transfer strictly in ascending order 0..511; the counter SHALL NOT wrap within a block.
REQ-027 DONE SHALL clear sd_ack for 1 cycle, pulse blk_err if the block was out of range, then go to IDLE.
REQ-028 No request SHALL be granted in the DONE cycle.
REQ-029 sd_ack SHALL be one-hot or zero; sd_buff_wr SHALL never assert during a write operation.
REQ-030 Request deassertion mid-transfer SHALL be ignored; the block always completes.
REQ-031 A cfg_wr for the active drive SHALL take effect at the next GRANT only; the range check is latched at GRANT.
REQ-032 With mem_ready tied high, a read block SHALL take 1024 cycles from GRANT to DONE and a write block 1536 cycles.

Reset
REQ-033 RESET_N low SHALL immediately force IDLE and sd_ack=0, sd_buff_wr=0, mem_rd=0, mem_wr=0, blk_err=0, sd_buff_addr=0, sd_buff_dout=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset SHALL clear all cfg_size to 0, set all arm bits to 1 and set the round-robin pointer to drive 0.
REQ-035 Reset mid-transfer SHALL abandon the block with no further buffer or memory writes.

Verification
REQ-036 cfg drive0 size 368640; sd_rd[0]=1, lba=5; mem_ready=1 -> sd_ack[0]=1; 512 sd_buff_wr pulses, addr 0..511; mem_addr 0x000A00..0x000BFF; ack low after 1024 cycles.
REQ-037 sd_rd[1] and sd_rd[2] high together, last served=1 -> drive 2 granted first, then drive 1 after drive 2's DONE.
REQ-038 Drive 3, size 0, sd_wr[3]=1 -> no mem_wr; 512 buffer reads; blk_err pulses once; ack low.
REQ-039 sd_rd[0] held high after ack drops -> no second grant until sd_rd[0] is seen low.
REQ-040 Write on drive 1, lba 2, mem_ready random 0/1 -> mem_wdata sequence equals the client buffer; mem_addr 0x100400 upward.
REQ-041 RESET_N low at byte 200 of a read -> sd_ack=0 and mem_rd=0 at once; after release, IDLE and the same request re-served from byte 0.

Source files
------------

// File: rtl/sd_blk_server.sv
// Block server: moves 512-byte blocks between per-drive client buffers and a
// shared byte-wide backing store, one drive at a time in round-robin order.
module sd_blk_server #(
  parameter int NDRIVES = 4,
  parameter int MEM_AW  = 22
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [31:0]        sd_lba [NDRIVES],
  input  logic [NDRIVES-1:0] sd_rd,
  input  logic [NDRIVES-1:0] sd_wr,
  output logic [NDRIVES-1:0] sd_ack,
  output logic [8:0]         sd_buff_addr,
  output logic [7:0]         sd_buff_dout,
  output logic               sd_buff_wr,
  input  logic [7:0]         sd_buff_din [NDRIVES],
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_drive,
  input  logic [19:0]        cfg_size,
  output logic [MEM_AW-1:0]  mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_ready,
  output logic               blk_err
);

  localparam int DW = 2;

  typedef enum logic [2:0] {
    IDLE, GRANT, RD_REQ, RD_PUSH, WR_ADDR, WR_SAMPLE, WR_REQ, DONE
  } state_t;

  state_t             state, state_nxt;
  logic [DW-1:0]      drive;
  logic [DW-1:0]      rr_next;
  logic [DW-1:0]      pick_drive;
  logic [DW-1:0]      cand;
  logic               pick_found;
  logic [10:0]        lba;
  logic [8:0]         cnt;
  logic [7:0]         byte_q;
  logic               in_range;
  logic [NDRIVES-1:0] arm;
  logic [NDRIVES-1:0] req_vec;
  logic [19:0]        size_tab [NDRIVES];
  logic               last_byte;
  logic               mem_done;

  assign req_vec   = arm & (sd_rd | sd_wr);
  assign last_byte = (cnt == 9'd511);
  // Out-of-range blocks never touch memory, so each byte step completes at once.
  assign mem_done  = !in_range || mem_ready;

  assign sd_buff_addr = cnt;
  assign sd_buff_dout = byte_q;
  assign mem_wdata    = byte_q;
  assign mem_addr     = MEM_AW'({drive, lba, cnt});

  // First armed requester at or after rr_next, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_drive = '0;
    cand       = '0;
    for (int k = 0; k < NDRIVES; k++) begin
      cand = DW'((int'(rr_next) + k) % NDRIVES);
      if (!pick_found && req_vec[cand]) begin
        pick_found = 1'b1;
        pick_drive = cand;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sd_ack     = '0;
    sd_buff_wr = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    blk_err    = 1'b0;
    case (state)
      IDLE:      if (pick_found) state_nxt = GRANT;
      GRANT:     state_nxt = sd_rd[drive] ? RD_REQ : WR_ADDR;
      RD_REQ: begin
        sd_ack[drive] = 1'b1;
        mem_rd        = in_range;
        if (mem_done) state_nxt = RD_PUSH;
      end
      RD_PUSH: begin
        sd_ack[drive] = 1'b1;
        sd_buff_wr    = 1'b1;
        state_nxt     = last_byte ? DONE : RD_REQ;
      end
      WR_ADDR: begin
        sd_ack[drive] = 1'b1;
        state_nxt     = WR_SAMPLE;
      end
      WR_SAMPLE: begin
        sd_ack[drive] = 1'b1;
        state_nxt     = WR_REQ;
      end
      WR_REQ: begin
        sd_ack[drive] = 1'b1;
        mem_wr        = in_range;
        if (mem_done) state_nxt = last_byte ? DONE : WR_ADDR;
      end
      DONE: begin
        blk_err   = !in_range;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Arm bits re-set whenever a drive is seen idle; the grant clear wins.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      drive    <= '0;
      rr_next  <= '0;
      lba      <= '0;
      cnt      <= '0;
      byte_q   <= '0;
      in_range <= 1'b0;
      arm      <= '1;
      for (int i = 0; i < NDRIVES; i++) size_tab[i] <= '0;
    end else begin
      if (cfg_wr) size_tab[cfg_drive] <= cfg_size;
      for (int i = 0; i < NDRIVES; i++) begin
        if (!sd_rd[i] && !sd_wr[i]) arm[i] <= 1'b1;
      end
      case (state)
        IDLE: if (pick_found) drive <= pick_drive;
        GRANT: begin
          lba         <= sd_lba[drive][10:0];
          cnt         <= '0;
          arm[drive]  <= 1'b0;
          in_range    <= (size_tab[drive] != '0) &&
                         (sd_lba[drive] < {21'd0, size_tab[drive][19:9]});
          rr_next     <= DW'((int'(drive) + 1) % NDRIVES);
        end
        RD_REQ: begin
          if (!in_range)     byte_q <= '0;
          else if (mem_ready) byte_q <= mem_rdata;
        end
        RD_PUSH:   if (!last_byte) cnt <= cnt + 9'd1;
        WR_SAMPLE: byte_q <= sd_buff_din[drive];
        WR_REQ:    if (mem_done && !last_byte) cnt <= cnt + 9'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_blk_server.sv
// Scoreboard bench for sd_blk_server: models client buffers and backing store,
// queues expected buffer/memory traffic and grants, and compares as they occur.
module tb_sd_blk_server;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] sd_lba [4];
  logic [3:0]  sd_rd;
  logic [3:0]  sd_wr;
  logic [3:0]  sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din [4];
  logic        cfg_wr;
  logic [1:0]  cfg_drive;
  logic [19:0] cfg_size;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        blk_err;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_bw [$];
  logic [21:0] exp_mr [$];
  logic [29:0] exp_mw [$];
  int          exp_grant [$];
  logic [7:0]  cbuf [4][512];
  logic [19:0] cfg_model [4];
  int          blk_cnt = 0;
  int          exp_blk = 0;
  int          ack_multi = 0;
  logic [3:0]  prev_ack = '0;
  logic        rnd_ready = 1'b0;
  logic [8:0]  addr_q;
  logic [16:0] mon_bw;
  logic [21:0] mon_mr;
  logic [29:0] mon_mw;
  int          mon_g;
  int          n;

  sd_blk_server #(.NDRIVES(4), .MEM_AW(22)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .cfg_wr       (cfg_wr),
    .cfg_drive    (cfg_drive),
    .cfg_size     (cfg_size),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .blk_err      (blk_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] memPattern(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hA5;
  endfunction

  assign mem_rdata = memPattern(mem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int d, input bit wr, input logic [31:0] lba);
    bit          inr;
    logic [21:0] a;
    inr = (cfg_model[d] != 0) && (lba < ({12'd0, cfg_model[d]} >> 9));
    exp_grant.push_back(d);
    if (!inr) exp_blk++;
    for (int i = 0; i < 512; i++) begin
      a = {d[1:0], lba[10:0], i[8:0]};
      if (wr) begin
        if (inr) exp_mw.push_back({a, cbuf[d][i]});
      end else begin
        exp_bw.push_back({i[8:0], inr ? memPattern(a) : 8'h00});
        if (inr) exp_mr.push_back(a);
      end
    end
    sd_lba[d] = lba;
    if (wr) sd_wr[d] = 1'b1;
    else    sd_rd[d] = 1'b1;
  endtask

  task automatic cfgWrite(input int d, input logic [19:0] size);
    cfg_drive = d[1:0];
    cfg_size  = size;
    cfg_wr    = 1'b1;
    @(negedge CLK);
    cfg_wr       = 1'b0;
    cfg_model[d] = size;
  endtask

  task automatic releaseReq(input int d);
    sd_rd[d] = 1'b0;
    sd_wr[d] = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic runBlock(input string tag, input int exp_len, input bit exact);
    int w;
    int len;
    w = 0;
    while (sd_ack == 0 && w < 100) begin @(negedge CLK); w++; end
    len = 0;
    while (sd_ack != 0 && len < 20000) begin @(negedge CLK); len++; end
    if (exact) checkOutput(tag, 32'(len), 32'(exp_len));
    else checkOutput(tag, (len >= exp_len && len < 20000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic drainCheck();
    checkOutput("bw_left", 32'(exp_bw.size()), 32'd0);
    checkOutput("mr_left", 32'(exp_mr.size()), 32'd0);
    checkOutput("mw_left", 32'(exp_mw.size()), 32'd0);
    checkOutput("grant_left", 32'(exp_grant.size()), 32'd0);
  endtask

  // Observe DUT traffic mid-cycle and retire scoreboard entries.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (sd_ack != 0 && prev_ack == 0) begin
        if (exp_grant.size() == 0) checkOutput("grant_unexp", 32'(sd_ack), 32'd0);
        else begin
          mon_g = exp_grant.pop_front();
          checkOutput("grant", 32'(sd_ack), 32'd1 << mon_g);
        end
      end
      if ($countones(sd_ack) > 1) ack_multi++;
      if (sd_buff_wr) begin
        if (exp_bw.size() == 0) checkOutput("bw_unexp", 32'(sd_buff_wr), 32'd0);
        else begin
          mon_bw = exp_bw.pop_front();
          checkOutput("bw_addr", 32'(sd_buff_addr), 32'(mon_bw[16:8]));
          checkOutput("bw_data", 32'(sd_buff_dout), 32'(mon_bw[7:0]));
        end
      end
      if (mem_rd && mem_ready) begin
        if (exp_mr.size() == 0) checkOutput("mr_unexp", 32'(mem_rd), 32'd0);
        else begin
          mon_mr = exp_mr.pop_front();
          checkOutput("mr_addr", 32'(mem_addr), 32'(mon_mr));
        end
      end
      if (mem_wr && mem_ready) begin
        if (exp_mw.size() == 0) checkOutput("mw_unexp", 32'(mem_wr), 32'd0);
        else begin
          mon_mw = exp_mw.pop_front();
          checkOutput("mw_addr", 32'(mem_addr), 32'(mon_mw[29:8]));
          checkOutput("mw_data", 32'(mem_wdata), 32'(mon_mw[7:0]));
        end
      end
      if (blk_err) blk_cnt++;
    end
    prev_ack = sd_ack;
  end

  // Client buffers answer one cycle after the address is presented.
  initial begin
    for (int d = 0; d < 4; d++) sd_buff_din[d] = 8'h00;
    forever begin
      @(negedge CLK);
      addr_q = sd_buff_addr;
      @(posedge CLK);
      #1;
      for (int d = 0; d < 4; d++) sd_buff_din[d] = cbuf[d][addr_q];
    end
  end

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RESET_N   = 1'b0;
    sd_rd     = '0;
    sd_wr     = '0;
    cfg_wr    = 1'b0;
    cfg_drive = '0;
    cfg_size  = '0;
    for (int d = 0; d < 4; d++) begin
      sd_lba[d]    = '0;
      cfg_model[d] = '0;
      for (int i = 0; i < 512; i++) cbuf[d][i] = 8'($urandom);
    end
    repeat (3) @(negedge CLK);
    checkOutput("rst_ack", 32'(sd_ack), 32'd0);
    checkOutput("rst_bwr", 32'(sd_buff_wr), 32'd0);
    checkOutput("rst_mrd", 32'(mem_rd), 32'd0);
    checkOutput("rst_mwr", 32'(mem_wr), 32'd0);
    checkOutput("rst_err", 32'(blk_err), 32'd0);
    checkOutput("rst_baddr", 32'(sd_buff_addr), 32'd0);
    checkOutput("rst_bdout", 32'(sd_buff_dout), 32'd0);
    checkOutput("rst_maddr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Basic in-range read, then a held request must not be re-granted.
    cfgWrite(0, 20'd368640);
    applyStimulus(0, 1'b0, 32'd5);
    runBlock("rd0_len", 1024, 1'b1);
    n = 0;
    repeat (30) begin @(negedge CLK); if (sd_ack != 0) n++; end
    checkOutput("rd0_rearm", 32'(n), 32'd0);
    releaseReq(0);
    drainCheck();

    // Round-robin: after drive 1 is served, drive 2 wins a simultaneous request.
    cfgWrite(1, 20'h80000);
    cfgWrite(2, 20'h80000);
    applyStimulus(1, 1'b0, 32'd3);
    runBlock("rd1_len", 1024, 1'b1);
    releaseReq(1);
    drainCheck();
    applyStimulus(2, 1'b0, 32'd7);
    applyStimulus(1, 1'b0, 32'd9);
    runBlock("rr_d2_len", 1024, 1'b1);
    runBlock("rr_d1_len", 1024, 1'b1);
    releaseReq(1);
    releaseReq(2);
    drainCheck();

    // Unconfigured drive write: full exchange, no memory writes, one error pulse.
    applyStimulus(3, 1'b1, 32'd7);
    runBlock("wr3_len", 1536, 1'b1);
    releaseReq(3);
    drainCheck();
    checkOutput("wr3_err", 32'(blk_cnt), 32'(exp_blk));

    // Range boundary: first block past the image, then the last block inside it.
    applyStimulus(2, 1'b0, 32'd1024);
    runBlock("lba_over_len", 1024, 1'b1);
    releaseReq(2);
    drainCheck();
    applyStimulus(2, 1'b0, 32'd1023);
    runBlock("lba_last_len", 1024, 1'b1);
    releaseReq(2);
    drainCheck();

    // Shrinking the image mid-block only affects the following grant.
    applyStimulus(2, 1'b0, 32'd5);
    fork
      runBlock("cfg_len", 1024, 1'b1);
      begin
        repeat (100) @(negedge CLK);
        cfgWrite(2, 20'd0);
      end
    join
    releaseReq(2);
    drainCheck();
    applyStimulus(2, 1'b0, 32'd5);
    runBlock("cfg_new_len", 1024, 1'b1);
    releaseReq(2);
    drainCheck();

    // In-range write with a stalling backing store.
    for (int i = 0; i < 512; i++) cbuf[1][i] = 8'($urandom);
    rnd_ready = 1'b1;
    applyStimulus(1, 1'b1, 32'd2);
    runBlock("wr1_len", 1536, 1'b0);
    rnd_ready = 1'b0;
    releaseReq(1);
    drainCheck();

    // Reset in the middle of a read; the held request is served again from byte 0.
    cfgWrite(0, 20'd368640);
    applyStimulus(0, 1'b0, 32'd9);
    n = 0;
    while (exp_bw.size() > 312 && n < 2000) begin @(negedge CLK); n++; end
    checkOutput("rst_at200", 32'(exp_bw.size()), 32'd312);
    RESET_N = 1'b0;
    #1;
    checkOutput("arst_ack", 32'(sd_ack), 32'd0);
    checkOutput("arst_mrd", 32'(mem_rd), 32'd0);
    checkOutput("arst_bwr", 32'(sd_buff_wr), 32'd0);
    exp_bw.delete();
    exp_mr.delete();
    exp_mw.delete();
    exp_grant.delete();
    for (int d = 0; d < 4; d++) cfg_model[d] = '0;
    repeat (3) @(negedge CLK);
    applyStimulus(0, 1'b0, 32'd9);
    RESET_N = 1'b1;
    runBlock("rerun_len", 1024, 1'b1);
    releaseReq(0);
    drainCheck();

    checkOutput("ack_1hot", 32'(ack_multi), 32'd0);
    checkOutput("blk_cnt", 32'(blk_cnt), 32'(exp_blk));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
